// File: rtl/updown_mod_counter.sv
// Up/down modulo-MODULUS counter with synchronous clamped load, terminal count and wrap pulse.
// Define COUNTER_SATURATE_EN to pin the count at its limits instead of wrapping.
module updown_mod_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             reverse,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  if (WIDTH < 1 || MODULUS < 2 || 64'(MODULUS) > (64'(1) << WIDTH)) begin : g_bad_params
    $error("updown_mod_counter: need WIDTH>=1 and 2 <= MODULUS <= 2**WIDTH");
  end

  logic [WIDTH-1:0] load_clamped;

  // Out-of-range load values pin to the top of the count range.
  always_comb begin
    load_clamped = load_val;
    if ({1'b0, load_val} >= MOD_EXT) load_clamped = LAST;
  end

  assign tc = reverse ? (q == '0) : (q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= load_clamped;
      wrap <= 1'b0;
    end else if (enable) begin
      if (!reverse) begin
        if (q == LAST) begin
`ifdef COUNTER_SATURATE_EN
          q    <= LAST;
          wrap <= 1'b0;
`else
          q    <= '0;
          wrap <= 1'b1;
`endif
        end else begin
          q    <= q + WIDTH'(1);
          wrap <= 1'b0;
        end
      end else begin
        if (q == '0) begin
`ifdef COUNTER_SATURATE_EN
          q    <= '0;
          wrap <= 1'b0;
`else
          q    <= LAST;
          wrap <= 1'b1;
`endif
        end else begin
          q    <= q - WIDTH'(1);
          wrap <= 1'b0;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: a MODULUS=10 instance and a MODULUS=16 instance.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst, enable, reverse, load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, wrap;

  logic       b_enable, b_reverse, b_load;
  logic [3:0] b_load_val;
  logic [3:0] b_q;
  logic       b_tc, b_wrap;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rst(rst), .enable(enable), .reverse(reverse), .load(load),
    .load_val(load_val), .q(q), .tc(tc), .wrap(wrap)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .rst(rst), .enable(b_enable), .reverse(b_reverse), .load(b_load),
    .load_val(b_load_val), .q(b_q), .tc(b_tc), .wrap(b_wrap)
  );

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; reverse = 1'b0; load = 1'b0; load_val = 4'd0;
    b_enable = 1'b0; b_reverse = 1'b0; b_load = 1'b0; b_load_val = 4'd0;
    step();
    check("reset_q", 8'(q), 8'd0);
    check("reset_wrap", 8'(wrap), 8'd0);
    check("reset_tc_up", 8'(tc), 8'd0);
    reverse = 1'b1; #1;
    check("reset_tc_down", 8'(tc), 8'd1);
    reverse = 1'b0;

    // Reset beats load and enable mid-count
    rst = 1'b0; load = 1'b1; load_val = 4'd5;
    step();
    check("preload_5", 8'(q), 8'd5);
    rst = 1'b1; load = 1'b1; enable = 1'b1; load_val = 4'd7;
    step();
    check("rst_over_load_q", 8'(q), 8'd0);
    check("rst_over_load_wrap", 8'(wrap), 8'd0);

    // Load beats enable; out-of-range values clamp
    rst = 1'b0; load = 1'b1; load_val = 4'd7; enable = 1'b1;
    step();
    check("load_7", 8'(q), 8'd7);
    load_val = 4'd13;
    step();
    check("load_13_clamp", 8'(q), 8'd9);
    check("load_13_tc", 8'(tc), 8'd1);
    load_val = 4'd0; reverse = 1'b1;
    step();
    check("load_0_q", 8'(q), 8'd0);
    check("load_0_tc_down", 8'(tc), 8'd1);

    // Hold and per-cycle direction change
    reverse = 1'b0; load_val = 4'd4;
    step();
    load = 1'b0; enable = 1'b0;
    step(); check("hold1", 8'(q), 8'd4);
    step(); check("hold2", 8'(q), 8'd4);
    step(); check("hold3", 8'(q), 8'd4);
    check("hold_wrap", 8'(wrap), 8'd0);
    enable = 1'b1;
    reverse = 1'b0; step(); check("toggle_up1", 8'(q), 8'd5);
    reverse = 1'b1; step(); check("toggle_dn1", 8'(q), 8'd4);
    reverse = 1'b0; step(); check("toggle_up2", 8'(q), 8'd5);
    reverse = 1'b1; step(); check("toggle_dn2", 8'(q), 8'd4);

`ifdef COUNTER_SATURATE_EN
    load = 1'b1; load_val = 4'd8; reverse = 1'b0;
    step();
    load = 1'b0; enable = 1'b1;
    step(); check("sat_up1", 8'(q), 8'd9);
    step(); check("sat_up2", 8'(q), 8'd9);
    step(); check("sat_up3", 8'(q), 8'd9);
    check("sat_up_wrap", 8'(wrap), 8'd0);
    check("sat_up_tc", 8'(tc), 8'd1);
    load = 1'b1; load_val = 4'd1; reverse = 1'b1;
    step();
    load = 1'b0;
    step(); check("sat_dn1", 8'(q), 8'd0);
    step(); check("sat_dn2", 8'(q), 8'd0);
    check("sat_dn_wrap", 8'(wrap), 8'd0);
    check("sat_dn_tc", 8'(tc), 8'd1);
`else
    // Up count through a full period from 0
    load = 1'b1; load_val = 4'd0; reverse = 1'b0;
    step();
    load = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("up_q_%0d", i), 8'(q), 8'(i % 10));
      check($sformatf("up_wrap_%0d", i), 8'(wrap), (i == 10) ? 8'd1 : 8'd0);
      check($sformatf("up_tc_%0d", i), 8'(tc), (i == 9) ? 8'd1 : 8'd0);
    end

    // Down count wraps 0 -> 9
    reverse = 1'b1; #1;
    check("down_tc_at0", 8'(tc), 8'd1);
    step();
    check("down_wrap_q", 8'(q), 8'd9);
    check("down_wrap", 8'(wrap), 8'd1);
    check("down_tc_at9", 8'(tc), 8'd0);
    step();
    check("down_q8", 8'(q), 8'd8);
    check("down_wrap_clear", 8'(wrap), 8'd0);

    // Load clears a pending wrap pulse
    load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0;
    step();
    check("wrap_before_load", 8'(wrap), 8'd1);
    load = 1'b1; load_val = 4'd3;
    step();
    check("load_after_wrap_q", 8'(q), 8'd3);
    check("load_after_wrap", 8'(wrap), 8'd0);

    // Disable clears a pending wrap pulse
    load_val = 4'd0;
    step();
    load = 1'b0;
    step();
    check("wrap_before_hold", 8'(wrap), 8'd1);
    enable = 1'b0;
    step();
    check("hold_after_wrap_q", 8'(q), 8'd9);
    check("hold_after_wrap", 8'(wrap), 8'd0);

    // MODULUS == 2**WIDTH: natural binary rollover
    b_load = 1'b1; b_load_val = 4'd15;
    step();
    check("m16_load15", 8'(b_q), 8'd15);
    check("m16_tc", 8'(b_tc), 8'd1);
    b_load = 1'b0; b_enable = 1'b1;
    step();
    check("m16_roll_q", 8'(b_q), 8'd0);
    check("m16_roll_wrap", 8'(b_wrap), 8'd1);
    step();
    check("m16_next_q", 8'(b_q), 8'd1);
    check("m16_next_wrap", 8'(b_wrap), 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
